// File: rtl/jtframe_sdram.sv
// Build-time limits for the SDRAM read controller.
// The controller top is jtframe_sdram_rdctl.
package jtframe_sdram_build_pkg;
    localparam int LEGAL_CL_MIN = 2;
    localparam int LEGAL_CL_MAX = 3;
endpackage

// File: rtl/jtframe_sdram_pkg.sv
// Shared definitions for the read-only SDRAM controller.
//   - command encodings as driven on {ncs, nras, ncas, nwe}
//   - mode-register bit layout and a builder for the init-time mode word
//   - controller state enum
package jtframe_sdram_pkg;

    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACT     = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_MRS     = 4'b0000;

    localparam int WAIT_W = 14;

    typedef struct packed {
        logic [2:0] reserved;      // A12..A10
        logic       write_single;  // A9: 0 = burst write
        logic [1:0] op_mode;       // A8..A7
        logic [2:0] cas_lat;       // A6..A4
        logic       interleave;    // A3: 0 = sequential
        logic [2:0] burst_len;     // A2..A0: 3'b001 = BL2
    } mode_reg_t;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_REF1,
        ST_INIT_REF2,
        ST_INIT_MRS,
        ST_IDLE,
        ST_ACT,
        ST_RD,
        ST_CAPTURE,
        ST_REFRESH
    } state_t;

    function automatic logic [12:0] mode_word(input logic [2:0] cas_lat);
        mode_reg_t m;
        m.reserved     = 3'b000;
        m.write_single = 1'b0;
        m.op_mode      = 2'b00;
        m.cas_lat      = cas_lat;
        m.interleave   = 1'b0;
        m.burst_len    = 3'b001;
        return m;
    endfunction

endpackage

// File: rtl/jtframe_sdram_reftimer.sv
// Saturating refresh interval counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the interval (an AUTO REFRESH is being issued)
//   en         : count only once the SDRAM is initialised
//   due        : interval elapsed; stays high until clr
module jtframe_sdram_reftimer
    import jtframe_sdram_pkg::*;
#(
    parameter logic [9:0] REF_PERIOD = 10'd750
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic due
);

    logic [9:0] cnt;

    // Saturates so a long read streak cannot wrap past the deadline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != REF_PERIOD) begin
            cnt <= cnt + 10'd1;
        end
    end

    assign due = (cnt == REF_PERIOD);

endmodule

// File: rtl/jtframe_sdram_rdctl.sv
// Read-only SDRAM command sequencer for one x16 bank (bank 0).
// Runs power-up init, periodic/opportunistic AUTO REFRESH and BL2 reads
// that return one 32-bit word per request.
//   clk, rst_n            : clock, async active-low reset
//   sdram_req/addr        : arbiter request (held until ack), word address
//   refresh_en            : opportunistic refresh hint
//   sdram_ack             : one-cycle pulse with the ACTIVE command
//   data_rdy/data_read    : one-cycle pulse with {high, low} burst data
//   init_done             : SDRAM initialised
//   sdram_*               : registered SDRAM pins, sdram_dq read only
//
// state      | meaning
// INIT_WAIT  | NOPs after reset release (power-up settle)
// INIT_PRE   | PRECHARGE ALL then tRP
// INIT_REF1  | first init AUTO REFRESH then tRFC
// INIT_REF2  | second init AUTO REFRESH then tRFC
// INIT_MRS   | LOAD MODE then one NOP
// IDLE       | arbitrate refresh due / request / refresh hint
// ACT        | ACTIVE issued, waiting tRCD
// RD         | READ with auto-precharge, waiting CAS latency
// CAPTURE    | second beat of the burst on the bus
// REFRESH    | AUTO REFRESH issued, waiting tRFC
module jtframe_sdram_rdctl
    import jtframe_sdram_pkg::*;
#(
    parameter int         CL         = 2,
    parameter int         TRCD       = 2,
    parameter int         TRP        = 2,
    parameter int         TRFC       = 7,
    parameter logic [13:0] INIT_WAIT = 14'd9600,
    parameter logic [9:0] REF_PERIOD = 10'd750
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_req,
    input  logic [21:0] sdram_addr,
    input  logic        refresh_en,
    output logic        sdram_ack,
    output logic        data_rdy,
    output logic [31:0] data_read,
    output logic        init_done,
    input  logic [15:0] sdram_dq,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba,
    output logic        sdram_ncs,
    output logic        sdram_nras,
    output logic        sdram_ncas,
    output logic        sdram_nwe,
    output logic        sdram_dqml,
    output logic        sdram_dqmh,
    output logic        sdram_cke
);

    localparam logic [WAIT_W-1:0] TRP_TC  = WAIT_W'(TRP);
    localparam logic [WAIT_W-1:0] TRFC_TC = WAIT_W'(TRFC);
    localparam logic [WAIT_W-1:0] REF_TC  = WAIT_W'(TRFC - 1);
    localparam logic [WAIT_W-1:0] ACT_TC  = WAIT_W'(TRCD - 1);
    localparam logic [WAIT_W-1:0] RD_TC   = WAIT_W'(CL);
    localparam logic [12:0]       MODE    = mode_word(3'(CL));

    state_t             state, st_nx;
    logic [WAIT_W-1:0]  wait_cnt, cnt_nx;
    logic [3:0]         cmd_q, cmd_nx;
    logic [12:0]        a_nx;
    logic [1:0]         dqm_q, dqm_nx;
    logic               ack_nx, rdy_nx, done_nx;
    logic               ref_clr, ref_due;
    logic               latch_col, latch_low, latch_data;
    logic [7:0]         col_q;
    logic [15:0]        low_q;
    logic               addr_lsb_unused;

    // Word address bit 0 selects a half of the 32-bit pair, which the BL2
    // burst always returns whole.
    assign addr_lsb_unused = sdram_addr[0];

    jtframe_sdram_reftimer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_reftimer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ref_clr),
        .en    (init_done),
        .due   (ref_due)
    );

    always_comb begin
        st_nx      = state;
        cnt_nx     = wait_cnt + 1'b1;
        cmd_nx     = CMD_NOP;
        a_nx       = '0;
        dqm_nx     = dqm_q;
        ack_nx     = 1'b0;
        rdy_nx     = 1'b0;
        done_nx    = init_done;
        ref_clr    = 1'b0;
        latch_col  = 1'b0;
        latch_low  = 1'b0;
        latch_data = 1'b0;
        case (state)
            ST_INIT_WAIT: if (wait_cnt == INIT_WAIT) begin
                st_nx  = ST_INIT_PRE;
                cnt_nx = '0;
                cmd_nx = CMD_PRE;
                a_nx   = 13'h0400;
            end
            ST_INIT_PRE: if (wait_cnt == TRP_TC) begin
                st_nx  = ST_INIT_REF1;
                cnt_nx = '0;
                cmd_nx = CMD_REF;
            end
            ST_INIT_REF1: if (wait_cnt == TRFC_TC) begin
                st_nx  = ST_INIT_REF2;
                cnt_nx = '0;
                cmd_nx = CMD_REF;
            end
            ST_INIT_REF2: if (wait_cnt == TRFC_TC) begin
                st_nx  = ST_INIT_MRS;
                cnt_nx = '0;
                cmd_nx = CMD_MRS;
                a_nx   = MODE;
            end
            // MRS cycle plus one NOP here; the first IDLE cycle is the
            // second NOP, so tMRD is met before any ACTIVE.
            ST_INIT_MRS: if (wait_cnt == WAIT_W'(1)) begin
                st_nx   = ST_IDLE;
                cnt_nx  = '0;
                done_nx = 1'b1;
                dqm_nx  = 2'b00;
            end
            ST_IDLE: begin
                cnt_nx = '0;
                if (ref_due) begin
                    st_nx   = ST_REFRESH;
                    cmd_nx  = CMD_REF;
                    ref_clr = 1'b1;
                end else if (sdram_req) begin
                    st_nx     = ST_ACT;
                    cmd_nx    = CMD_ACT;
                    a_nx      = sdram_addr[21:9];
                    ack_nx    = 1'b1;
                    latch_col = 1'b1;
                end else if (refresh_en) begin
                    st_nx   = ST_REFRESH;
                    cmd_nx  = CMD_REF;
                    ref_clr = 1'b1;
                end
            end
            // The REF cycle counts toward tRFC; IDLE supplies the last NOP.
            ST_REFRESH: if (wait_cnt == REF_TC) begin
                st_nx  = ST_IDLE;
                cnt_nx = '0;
            end
            ST_ACT: if (wait_cnt == ACT_TC) begin
                st_nx  = ST_RD;
                cnt_nx = '0;
                cmd_nx = CMD_READ;
                a_nx   = {2'b00, 1'b1, 1'b0, col_q, 1'b0};
            end
            ST_RD: if (wait_cnt == RD_TC) begin
                st_nx     = ST_CAPTURE;
                cnt_nx    = '0;
                latch_low = 1'b1;
            end
            ST_CAPTURE: begin
                st_nx      = ST_IDLE;
                cnt_nx     = '0;
                latch_data = 1'b1;
                rdy_nx     = 1'b1;
            end
            default: begin
                st_nx  = ST_INIT_WAIT;
                cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT_WAIT;
            wait_cnt  <= '0;
            cmd_q     <= CMD_INHIBIT;
            sdram_a   <= '0;
            dqm_q     <= 2'b11;
            sdram_cke <= 1'b0;
            sdram_ack <= 1'b0;
            data_rdy  <= 1'b0;
            data_read <= '0;
            init_done <= 1'b0;
            col_q     <= '0;
            low_q     <= '0;
        end else begin
            state     <= st_nx;
            wait_cnt  <= cnt_nx;
            cmd_q     <= cmd_nx;
            sdram_a   <= a_nx;
            dqm_q     <= dqm_nx;
            sdram_cke <= 1'b1;
            sdram_ack <= ack_nx;
            data_rdy  <= rdy_nx;
            init_done <= done_nx;
            if (latch_col)  col_q     <= sdram_addr[8:1];
            if (latch_low)  low_q     <= sdram_dq;
            if (latch_data) data_read <= {sdram_dq, low_q};
        end
    end

    assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd_q;
    assign {sdram_dqmh, sdram_dqml} = dqm_q;
    assign sdram_ba = 2'b00;

endmodule

// File: tb/tb_jtframe_sdram_rdctl.sv
module tb_jtframe_sdram_rdctl;
    import jtframe_sdram_pkg::*;

    localparam int CL_A = 2;
    localparam int CL_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance: default timing, CL=2
    logic        rst_n, req, refresh_en;
    logic [21:0] addr;
    logic        ack, data_rdy, init_done;
    logic [31:0] data_read;
    logic [15:0] dq;
    logic [12:0] a;
    logic [1:0]  ba;
    logic        ncs, nras, ncas, nwe, dqml, dqmh, cke;
    logic [3:0]  cmd;
    assign cmd = {ncs, nras, ncas, nwe};

    // second instance: CL=3, short power-up wait
    logic        rst3_n, req3, refresh_en3;
    logic [21:0] addr3;
    logic        ack3, data_rdy3, init_done3;
    logic [31:0] data_read3;
    logic [15:0] dq3;
    logic [12:0] a3;
    logic [1:0]  ba3;
    logic        ncs3, nras3, ncas3, nwe3, dqml3, dqmh3, cke3;
    logic [3:0]  cmd3;
    assign cmd3 = {ncs3, nras3, ncas3, nwe3};

    jtframe_sdram_rdctl #(.CL(CL_A)) u_dut (
        .clk(clk), .rst_n(rst_n), .sdram_req(req), .sdram_addr(addr),
        .refresh_en(refresh_en), .sdram_ack(ack), .data_rdy(data_rdy),
        .data_read(data_read), .init_done(init_done), .sdram_dq(dq),
        .sdram_a(a), .sdram_ba(ba), .sdram_ncs(ncs), .sdram_nras(nras),
        .sdram_ncas(ncas), .sdram_nwe(nwe), .sdram_dqml(dqml),
        .sdram_dqmh(dqmh), .sdram_cke(cke)
    );

    jtframe_sdram_rdctl #(.CL(CL_B), .INIT_WAIT(14'd20)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .sdram_req(req3), .sdram_addr(addr3),
        .refresh_en(refresh_en3), .sdram_ack(ack3), .data_rdy(data_rdy3),
        .data_read(data_read3), .init_done(init_done3), .sdram_dq(dq3),
        .sdram_a(a3), .sdram_ba(ba3), .sdram_ncs(ncs3), .sdram_nras(nras3),
        .sdram_ncas(ncas3), .sdram_nwe(nwe3), .sdram_dqml(dqml3),
        .sdram_dqmh(dqmh3), .sdram_cke(cke3)
    );

    // SDRAM read-data model: low word in cycle READ+CL, high word next cycle.
    logic [15:0] lo_word = 16'h0000;
    logic [15:0] hi_word = 16'h0000;
    int rd_cyc  = -100;
    int rd3_cyc = -100;
    initial begin dq = 16'hDEAD; dq3 = 16'hDEAD; end
    always @(negedge clk) begin
        if (cmd == CMD_READ) rd_cyc = cyc;
        if (cyc == rd_cyc + CL_A)          dq = lo_word;
        else if (cyc == rd_cyc + CL_A + 1) dq = hi_word;
        else                               dq = 16'hDEAD;
        if (cmd3 == CMD_READ) rd3_cyc = cyc;
        if (cyc == rd3_cyc + CL_B)          dq3 = lo_word;
        else if (cyc == rd3_cyc + CL_B + 1) dq3 = hi_word;
        else                                dq3 = 16'hDEAD;
    end

    int ack_cnt = 0, rdy_cnt = 0, ack3_cnt = 0;
    always @(posedge clk) begin
        #2;
        if (ack)      ack_cnt++;
        if (data_rdy) rdy_cnt++;
        if (ack3)     ack3_cnt++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles until the given command is on the pins; -1 if budget expires.
    task automatic wait_cmd(input bit sel3, input logic [3:0] target, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sel3 ? cmd3 : cmd) !== target && n < budget);
        if ((sel3 ? cmd3 : cmd) !== target) n = -1;
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return init_done;
            1:       return data_rdy;
            2:       return init_done3;
            default: return data_rdy3;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sig_sel(which) !== 1'b1 && n < budget);
        if (sig_sel(which) !== 1'b1) n = -1;
    endtask

    int n;
    int rdy_before, ack_before;

    initial begin
        rst_n = 1'b0; req = 1'b0; addr = '0; refresh_en = 1'b0;
        rst3_n = 1'b0; req3 = 1'b0; addr3 = '0; refresh_en3 = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cmd", cmd, CMD_INHIBIT);
        check("rst_a", a, 13'h0000);
        check("rst_ba", ba, 2'b00);
        check("rst_dqm", {dqmh, dqml}, 2'b11);
        check("rst_cke", cke, 1'b0);
        check("rst_ack_rdy", {ack, data_rdy, init_done}, 3'b000);
        check("rst_data", data_read, 32'h0);

        // ---- CL=3 instance: init, then one read (addr 22'h2A5B3 -> row 0x152)
        rst3_n = 1'b1;
        wait_cmd(1, CMD_PRE, 100, n);   check("c3_pre_at", n, 21);
        check("c3_pre_a10", a3, 13'h0400);
        wait_cmd(1, CMD_REF, 20, n);    check("c3_ref1_gap", n, 3);
        wait_cmd(1, CMD_REF, 20, n);    check("c3_ref2_gap", n, 8);
        wait_cmd(1, CMD_MRS, 20, n);    check("c3_mrs_gap", n, 8);
        check("c3_mrs_a", a3, 13'h031);
        wait_sig(2, 10, n);             check("c3_done_gap", n, 2);
        req3 = 1'b1; addr3 = 22'h2A5B3;
        lo_word = 16'h1234; hi_word = 16'hABCD;
        wait_cmd(1, CMD_ACT, 5, n);     check("c3_act_gap", n, 1);
        check("c3_act_row", a3, 13'h0152);
        check("c3_ack", ack3, 1'b1);
        req3 = 1'b0; addr3 = 22'h3FFFFF;
        wait_cmd(1, CMD_READ, 10, n);   check("c3_trcd", n, 2);
        check("c3_read_a", a3, 13'h05B2);
        wait_sig(3, 20, n);             check("c3_rdy_lat", n, 5);
        check("c3_data", data_read3, 32'hABCD1234);
        @(negedge clk);
        check("c3_rdy_pulse", data_rdy3, 1'b0);
        check("c3_data_hold", data_read3, 32'hABCD1234);
        check("c3_one_ack", ack3_cnt, 1);

        // ---- main instance: req held through init must be ignored until init_done
        req = 1'b1; addr = 22'h2A57B3;   // row 0x152B, column bits 0xD9
        lo_word = 16'h1234; hi_word = 16'hABCD;
        rst_n = 1'b1;
        @(negedge clk);
        check("init_cke", cke, 1'b1);
        check("init_nop", cmd, CMD_NOP);
        wait_cmd(0, CMD_PRE, 12000, n); check("init_pre_at", n, 9600);
        check("init_pre_a10", a, 13'h0400);
        wait_cmd(0, CMD_REF, 20, n);    check("init_ref1_gap", n, 3);
        wait_cmd(0, CMD_REF, 20, n);    check("init_ref2_gap", n, 8);
        wait_cmd(0, CMD_MRS, 20, n);    check("init_mrs_gap", n, 8);
        check("init_mrs_a", a, 13'h021);
        check("init_no_ack", ack_cnt, 0);
        check("init_done_low", init_done, 1'b0);
        wait_sig(0, 10, n);             check("init_done_gap", n, 2);
        check("init_dqm", {dqmh, dqml}, 2'b00);

        // first read
        wait_cmd(0, CMD_ACT, 5, n);     check("rd1_act_gap", n, 1);
        check("rd1_row", a, 13'h152B);
        check("rd1_ack", ack, 1'b1);
        req = 1'b0; addr = 22'h000000;
        wait_cmd(0, CMD_READ, 10, n);   check("rd1_trcd", n, 2);
        check("rd1_read_a", a, 13'h05B2);
        wait_sig(1, 20, n);             check("rd1_rdy_lat", n, 4);
        check("rd1_data", data_read, 32'hABCD1234);
        @(negedge clk);
        check("rd1_rdy_pulse", data_rdy, 1'b0);

        // second read: column 0, bit 0 of the address has no effect
        req = 1'b1; addr = 22'h000001;
        lo_word = 16'h0F0F; hi_word = 16'h5A5A;
        wait_cmd(0, CMD_ACT, 5, n);     check("rd2_act_gap", n, 1);
        check("rd2_row", a, 13'h0000);
        req = 1'b0;
        wait_cmd(0, CMD_READ, 10, n);   check("rd2_read_a", a, 13'h0400);
        wait_sig(1, 20, n);             check("rd2_rdy_lat", n, 4);
        check("rd2_data", data_read, 32'h5A5A0F0F);

        // opportunistic refresh: one REF every TRFC+1 cycles
        refresh_en = 1'b1;
        wait_cmd(0, CMD_REF, 5, n);     check("ren_first", n, 1);
        check("ren_refcnt_clr", u_dut.u_reftimer.cnt, 0);
        wait_cmd(0, CMD_REF, 20, n);    check("ren_period1", n, 8);
        wait_cmd(0, CMD_REF, 20, n);    check("ren_period2", n, 8);
        repeat (3) @(negedge clk);
        req = 1'b1; addr = 22'h155555;
        wait_cmd(0, CMD_ACT, 20, n);    check("ren_req_after_trfc", n, 5);
        refresh_en = 1'b0;

        // req held continuously: ref_cnt saturates, REF cuts in before the next ACT
        wait_cmd(0, CMD_REF, 1000, n);  check("mand_ref_at", n, 749);
        check("mand_refcnt_clr", u_dut.u_reftimer.cnt, 0);
        wait_cmd(0, CMD_ACT, 20, n);    check("mand_act_after", n, 8);
        req = 1'b0;
        wait_sig(1, 20, n);             check("mand_rdy_lat", n, 6);

        // reset during cycle READ+1 aborts the read and replays init
        req = 1'b1; addr = 22'h0ABCDE;
        lo_word = 16'h7777; hi_word = 16'h8888;
        wait_cmd(0, CMD_ACT, 5, n);     check("rr_act_gap", n, 1);
        req = 1'b0;
        wait_cmd(0, CMD_READ, 10, n);   check("rr_trcd", n, 2);
        rdy_before = rdy_cnt;
        ack_before = ack_cnt;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rr_cmd", cmd, CMD_INHIBIT);
        check("rr_cke", cke, 1'b0);
        check("rr_done", init_done, 1'b0);
        check("rr_dqm", {dqmh, dqml}, 2'b11);
        check("rr_data", data_read, 32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        wait_cmd(0, CMD_PRE, 12000, n); check("rr_pre_at", n, 9601);
        wait_cmd(0, CMD_REF, 20, n);    check("rr_ref1_gap", n, 3);
        wait_cmd(0, CMD_REF, 20, n);    check("rr_ref2_gap", n, 8);
        wait_cmd(0, CMD_MRS, 20, n);    check("rr_mrs_gap", n, 8);
        wait_sig(0, 10, n);             check("rr_done_gap", n, 2);
        check("rr_no_rdy", rdy_cnt, rdy_before);
        check("rr_no_ack", ack_cnt, ack_before);

        // read at the top of the address space after the replayed init
        req = 1'b1; addr = 22'h3FFFFF;
        lo_word = 16'hFFFF; hi_word = 16'h0000;
        wait_cmd(0, CMD_ACT, 5, n);     check("rd3_act_gap", n, 1);
        check("rd3_row", a, 13'h1FFF);
        req = 1'b0;
        wait_cmd(0, CMD_READ, 10, n);   check("rd3_read_a", a, 13'h05FE);
        wait_sig(1, 20, n);             check("rd3_rdy_lat", n, 4);
        check("rd3_data", data_read, 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
